// File: rtl/irq_vector_controller.sv
// -----------------------------------------------------------------------------
// irq_vector_controller
//
// Purpose:
//   Latches up to NUM_IRQ interrupt sources, qualifies them with a per-channel
//   mask and a global interrupt enable, and picks the lowest-numbered eligible
//   channel. One vectored request is presented at a time. Once the core
//   accepts it, the controller stays in a service window until the core
//   signals return-from-interrupt. Each channel has its own vector:
//   ISR_BASE + id * VECTOR_STRIDE, computed modulo 2^ADDR_BITS.
//
// Optional feature (compile-time macro):
//   IRQ_EDGE_TRIGGER_EN - when defined, pending bits are set by rising edges of
//                         irq_in. A previous-sample register provides the edge
//                         history. When undefined, the controller runs in level
//                         mode: pending sets in every cycle the line is high,
//                         and there is no edge-history register.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   irq_in       in   [NUM_IRQ] raw interrupt lines, synchronous to clk
//   mask_we      in   mask register write strobe
//   mask_wdata   in   [NUM_IRQ] new mask value (1 = channel enabled)
//   mask_q       out  [NUM_IRQ] current mask
//   gie_set      in   global enable set (EI)
//   gie_clr      in   global enable clear (DI), wins over gie_set
//   gie_q        out  current global enable
//   pending_q    out  [NUM_IRQ] latched pending bits
//   irq_req      out  vectored request to the core (REQUEST state)
//   irq_id       out  [ID_W] winning channel, frozen while requesting
//   irq_vector   out  [ADDR_BITS] ISR entry for irq_id
//   irq_ack      in   core accepts the request at an instruction boundary
//   irq_done     in   core executed return-from-interrupt
//   busy         out  high while in SERVICE
// -----------------------------------------------------------------------------
module irq_vector_controller #(
   parameter int          NUM_IRQ       = 8,
   parameter int          ADDR_BITS     = 16,
   parameter int unsigned ISR_BASE      = 'hff00,
   parameter int unsigned VECTOR_STRIDE = 8,
   localparam int         ID_W          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_IRQ-1:0]   irq_in,
   input  logic                 mask_we,
   input  logic [NUM_IRQ-1:0]   mask_wdata,
   output logic [NUM_IRQ-1:0]   mask_q,
   input  logic                 gie_set,
   input  logic                 gie_clr,
   output logic                 gie_q,
   output logic [NUM_IRQ-1:0]   pending_q,
   output logic                 irq_req,
   output logic [ID_W-1:0]      irq_id,
   output logic [ADDR_BITS-1:0] irq_vector,
   input  logic                 irq_ack,
   input  logic                 irq_done,
   output logic                 busy
);

   localparam logic [ADDR_BITS-1:0] BASE_A   = ADDR_BITS'(ISR_BASE);
   localparam logic [ADDR_BITS-1:0] STRIDE_A = ADDR_BITS'(VECTOR_STRIDE);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t                 state_reg, state_next;
   logic [NUM_IRQ-1:0]     pending_reg, pending_next;
   logic [NUM_IRQ-1:0]     mask_reg, mask_next;
   logic                   gie_reg, gie_next;
   logic [ID_W-1:0]        irq_id_reg, irq_id_next;
   logic [ADDR_BITS-1:0]   irq_vector_reg, irq_vector_next;

   logic [NUM_IRQ-1:0]     set_vec;
   logic [NUM_IRQ-1:0]     clr_vec;
   logic [NUM_IRQ-1:0]     eligible;
   logic                   any_eligible;
   logic [ID_W-1:0]        winner_id;
   logic                   load_winner;
   logic                   accept;
   logic                   done_ok;

   // ---------------------------------------------------------------------
   // Pending-set source: edge detect or raw level
   // ---------------------------------------------------------------------
`ifdef IRQ_EDGE_TRIGGER_EN
   logic [NUM_IRQ-1:0] irq_prev_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_prev_reg <= '0;
      end else begin
         irq_prev_reg <= irq_in;
      end
   end

   assign set_vec = irq_in & ~irq_prev_reg;
`else
   assign set_vec = irq_in;
`endif

   // ---------------------------------------------------------------------
   // Per-channel pending bits. The set term is OR-ed last, so an arrival in
   // the same cycle as the acknowledge-clear keeps the bit set.
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pending
         assign clr_vec[gi]      = accept && (irq_id_reg == ID_W'(gi));
         assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Eligibility and fixed-priority pick (lowest index wins)
   // ---------------------------------------------------------------------
   assign eligible     = pending_reg & mask_reg & {NUM_IRQ{gie_reg}};
   assign any_eligible = |eligible;

   always_comb begin
      winner_id = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner_id = ID_W'(i);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Sequencer next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      load_winner = 1'b0;
      accept      = 1'b0;
      done_ok     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (any_eligible) begin
               load_winner = 1'b1;
               state_next  = ST_REQUEST;
            end
         end
         ST_REQUEST: begin
            // Committed: nothing but an acknowledge leaves this state.
            if (irq_ack) begin
               accept     = 1'b1;
               state_next = ST_SERVICE;
            end
         end
         ST_SERVICE: begin
            if (irq_done) begin
               done_ok    = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // id/vector only change when a new winner is latched in IDLE.
   always_comb begin
      irq_id_next     = irq_id_reg;
      irq_vector_next = irq_vector_reg;
      if (load_winner) begin
         irq_id_next     = winner_id;
         irq_vector_next = BASE_A + STRIDE_A * ADDR_BITS'(winner_id);
      end
   end

   // Global enable: software clear beats software set; the hardware actions
   // on acceptance and return beat both.
   always_comb begin
      gie_next = gie_reg;
      if (gie_set) begin
         gie_next = 1'b1;
      end
      if (gie_clr) begin
         gie_next = 1'b0;
      end
      if (accept) begin
         gie_next = 1'b0;
      end
      if (done_ok) begin
         gie_next = 1'b1;
      end
   end

   always_comb begin
      mask_next = mask_reg;
      if (mask_we) begin
         mask_next = mask_wdata;
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_IDLE;
         pending_reg    <= '0;
         mask_reg       <= '0;
         gie_reg        <= 1'b0;
         irq_id_reg     <= '0;
         irq_vector_reg <= BASE_A;
      end else begin
         state_reg      <= state_next;
         pending_reg    <= pending_next;
         mask_reg       <= mask_next;
         gie_reg        <= gie_next;
         irq_id_reg     <= irq_id_next;
         irq_vector_reg <= irq_vector_next;
      end
   end

   assign mask_q     = mask_reg;
   assign gie_q      = gie_reg;
   assign pending_q  = pending_reg;
   assign irq_id     = irq_id_reg;
   assign irq_vector = irq_vector_reg;
   assign irq_req    = (state_reg == ST_REQUEST);
   assign busy       = (state_reg == ST_SERVICE);

endmodule

// File: doc/irq_vector_controller.md
# irq_vector_controller

Parametrised interrupt controller that sits between peripheral interrupt lines and the core's execution-stage sequencer. It latches up to NUM_IRQ interrupt sources, applies a per-channel mask and a global enable, and arbitrates by fixed priority. It presents one vectored request at a time and tracks the service window until the core signals return-from-interrupt. It generalises the single fixed ISR entry (base 'hff00) to a table of per-channel vectors.

## Interface
- NUM_IRQ, 8, number of interrupt channels (1..16); channel 0 is highest priority.
- ADDR_BITS, 16, vector width; matches the memory address width.
- ISR_BASE, 'hff00, address of the channel-0 vector.
- VECTOR_STRIDE, 8, byte distance between consecutive channel vectors.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- irq_in  in  NUM_IRQ  raw interrupt lines, synchronous to clk.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  NUM_IRQ  new mask value; 1 = channel enabled.
- mask_q  out  NUM_IRQ  current mask.
- gie_set  in  1  global interrupt enable set (EI).
- gie_clr  in  1  global interrupt enable clear (DI).
- gie_q  out  1  current global enable.
- pending_q  out  NUM_IRQ  latched pending bits.
- irq_req  out  1  vectored request to the core.
- irq_id  out  $clog2(NUM_IRQ) (min 1)  winning channel.
- irq_vector  out  ADDR_BITS  ISR_BASE + irq_id*VECTOR_STRIDE.
- irq_ack  in  1  core accepts the request at an instruction boundary.
- irq_done  in  1  core executed return-from-interrupt.
- busy  out  1  high in SERVICE.

## Operation
- Pending capture, per channel: a condition (see Configuration) sets pending[i]. Acceptance of channel i clears it. A set and an acknowledge-clear in the same cycle resolve to set, so no event is lost.
- Eligible = pending & mask_q, considered only when gie_q = 1.
- Winner = lowest eligible index.
- State IDLE: if any channel is eligible, latch the winner into irq_id/irq_vector and go to REQUEST.
- State REQUEST: irq_req = 1. irq_id and irq_vector are frozen.
  - The request is committed: mask writes, gie_clr, and higher-priority arrivals do not withdraw or change it.
  - On irq_ack: clear pending[irq_id], force gie_q = 0, go to SERVICE.
- State SERVICE: busy = 1 and no new request is issued. On irq_done: gie_q = 1, go to IDLE.
- irq_done outside SERVICE and irq_ack outside REQUEST are ignored.
- GIE update:
  - gie_set and gie_clr together: clr wins.
  - Hardware clear on acceptance and hardware set on irq_done override software strobes in the same cycle.
- Mask update: mask_we writes mask_q on the next edge.
- Vector arithmetic is done in ADDR_BITS, modulo 2^ADDR_BITS. Example: ISR_BASE='hfff8, stride 8, id 1 gives 'h0000.
- Reset values:
  - state IDLE, irq_req 0, busy 0.
  - irq_id 0, irq_vector ISR_BASE.
  - pending_q 0, mask_q 0, gie_q 0.
  - edge-history register 0.
- Reset is asynchronous and can occur mid-request or mid-service; everything returns to the reset values immediately.

## Timing
- Edge k samples irq_in and sets pending. Edge k+1 enters REQUEST, so irq_req is high after edge k+1. Event-to-request latency is 2 cycles.
- Edge where irq_ack = 1: SERVICE is entered, irq_req drops, and pending/gie update at the same edge.
- irq_done at edge m gives IDLE and gie_q = 1 after m. The earliest next irq_req is after edge m+1.
- Priority is re-evaluated only in IDLE.

## Configuration
- IRQ_EDGE_TRIGGER_EN defined:
  - pending[i] sets on a rising edge of irq_in[i], i.e. the current sample is 1 and the registered previous sample is 0.
  - A held-high line produces exactly one event.
- IRQ_EDGE_TRIGGER_EN not defined (level mode):
  - pending[i] sets in every cycle irq_in[i] = 1, independent of mask.
  - A line still high after acknowledgement re-pends the next cycle.
  - The edge-history register is absent.

## Test plan
- Reset, mask 'hff, gie_set, pulse irq_in[3] for 1 cycle (edge mode) -> irq_req high 2 cycles later; irq_id 3; irq_vector 'hff18.
- irq_in[5] and irq_in[2] asserted together, mask 'hff, gie 1 -> irq_id 2. Ack, then irq_done -> irq_id 5, vector 'hff28.
- mask 'hf7, irq_in[3] pulsed -> no request. Write mask 'hff -> request for id 3 within 2 cycles.
- During REQUEST on id 4: pulse irq_in[0] and gie_clr -> irq_id stays 4 until ack. After done, id 0 is only serviced once gie_q = 1.
- Level mode: hold irq_in[1] high through ack and done -> pending_q[1] = 1 again one cycle after ack; second request after done.
- Assert reset_n = 0 during SERVICE -> busy, irq_req, gie_q, pending_q, mask_q all 0 immediately; irq_vector 'hff00.
